float32_to_sfrac32: RTL

//  Pipelined IEEE-754 single-precision to signed Q1.31 fraction converter.

---
 rtl/float32_to_sfrac32_if.sv | 21 ++
 rtl/float32_to_sfrac32.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/float32_to_sfrac32_if.sv
// Valid/ready stream bundle for the float32 -> Q1.31 converter: float input side and fraction output side.
interface float32_to_sfrac32_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_ovf;
   logic        out_nan;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_nan
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_nan
   );
endinterface

// File: rtl/float32_to_sfrac32.sv
// Three-stage IEEE-754 single to signed Q1.31 converter: classify, barrel-shift denormalise, sign/saturate.
module float32_to_sfrac32 #(
   parameter bit ROUND_NEAREST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   float32_to_sfrac32_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MANT_W = 24;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned SH_W   = 8;

   typedef enum logic [2:0] {
      CLS_NORMAL  = 3'd0,
      CLS_ZERO    = 3'd1,
      CLS_OVF     = 3'd2,
      CLS_INF     = 3'd3,
      CLS_NAN     = 3'd4,
      CLS_NEG_ONE = 3'd5
   } cls_e;

   logic en;

   logic [EXP_W-1:0]    in_e_c;
   logic [22:0]         in_m_c;
   logic                in_s_c;
   cls_e                in_cls_c;

   logic                s1_valid;
   logic                s1_sign;
   cls_e                s1_cls;
   logic [MANT_W-1:0]   s1_mant;
   logic signed [SH_W-1:0] s1_sh;

   logic [SH_W-1:0]     neg_c;
   logic [DATA_W-1:0]   lsh_c;
   logic [MANT_W:0]     rsh_c;
   logic [DATA_W-1:0]   mag_c;

   logic                s2_valid;
   logic                s2_sign;
   cls_e                s2_cls;
   logic [DATA_W-1:0]   s2_mag;

   logic [DATA_W-1:0]   res_c;
   logic                ovf_c;
   logic                nan_c;

   // Whole pipeline advances together unless the output word is stalled.
   assign en           = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = en;

   assign in_s_c = bus.in_data[31];
   assign in_e_c = bus.in_data[30:23];
   assign in_m_c = bus.in_data[22:0];

   always_comb begin
      in_cls_c = CLS_NORMAL;
      if (in_e_c == 8'hFF) begin
         in_cls_c = (in_m_c != 23'd0) ? CLS_NAN : CLS_INF;
      end else if (in_e_c == 8'd0) begin
         in_cls_c = CLS_ZERO;
      end else if (in_e_c >= 8'd127) begin
         in_cls_c = (in_s_c && (in_e_c == 8'd127) && (in_m_c == 23'd0)) ? CLS_NEG_ONE : CLS_OVF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_cls   <= CLS_ZERO;
         s1_mant  <= '0;
         s1_sh    <= '0;
      end else if (en) begin
         s1_valid <= bus.in_valid;
         s1_sign  <= in_s_c;
         s1_cls   <= in_cls_c;
         s1_mant  <= {1'b1, in_m_c};
         s1_sh    <= SH_W'(in_e_c - 8'd119);
      end
   end

   // Left shift covers 0..7; right shift keeps one extra LSB as the guard bit.
   assign neg_c = SH_W'(-s1_sh);
   assign lsh_c = {8'd0, s1_mant} << s1_sh[2:0];
   assign rsh_c = {s1_mant, 1'b0} >> neg_c[4:0];

   always_comb begin
      mag_c = '0;
      if (s1_cls == CLS_NORMAL) begin
         if (!s1_sh[SH_W-1]) begin
            mag_c = lsh_c;
         end else if (neg_c < 8'd25) begin
            mag_c = {8'd0, rsh_c[MANT_W:1]} + {31'd0, ROUND_NEAREST & rsh_c[0]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_cls   <= CLS_ZERO;
         s2_mag   <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_cls   <= s1_cls;
         s2_mag   <= mag_c;
      end
   end

   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      nan_c = 1'b0;
      case (s2_cls)
         CLS_NORMAL:  res_c = s2_sign ? ((~s2_mag) + 32'd1) : s2_mag;
         CLS_OVF,
         CLS_INF: begin
            res_c = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf_c = 1'b1;
         end
         CLS_NEG_ONE: res_c = 32'h8000_0000;
         CLS_NAN:     nan_c = 1'b1;
         default:     res_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ovf   <= 1'b0;
         bus.out_nan   <= 1'b0;
      end else if (en) begin
         bus.out_valid <= s2_valid;
         bus.out_data  <= res_c;
         bus.out_ovf   <= ovf_c;
         bus.out_nan   <= nan_c;
      end
   end
endmodule
